// File: rtl/if_rd_pkg.sv
// Shared types and default widths for the IF scratchpad read sequencer.
package if_rd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_READ    = 3'd2,
    ST_PUBLISH = 3'd3,
    ST_ADVANCE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam int unsigned DEF_ADDR_WIDTH = 16;
  localparam int unsigned DEF_DEPTH      = 256;
  localparam int unsigned DEF_LEN_W      = 8;
  localparam int unsigned DEF_CNT_W      = 16;

endpackage

// File: rtl/circ_addr_add.sv
// (a + b) mod DEPTH for a < DEPTH and b <= DEPTH; one conditional subtract suffices.
module circ_addr_add
  import if_rd_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH
) (
  input  logic [ADDR_WIDTH-1:0] a,
  input  logic [ADDR_WIDTH-1:0] b,
  output logic [ADDR_WIDTH-1:0] sum
);

  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH:0] raw;

  always_comb begin
    raw = {1'b0, a} + {1'b0, b};
    sum = ADDR_WIDTH'((raw >= DEPTH_EXT) ? (raw - DEPTH_EXT) : raw);
  end

endmodule

// File: rtl/if_window_reader.sv
// Read-side sequencer for the circular IF scratchpad: one sliding window at a time,
// filt_len sequential reads per window, end pointer published, head advanced by stride.
module if_window_reader
  import if_rd_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned LEN_W      = DEF_LEN_W,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      filt_len,
  input  logic [LEN_W-1:0]      stride,
  input  logic [CNT_W-1:0]      num_windows,
  input  logic [ADDR_WIDTH:0]   if_count,
  input  logic                  rd_ready,
  output logic                  IF_ren,
  output logic [ADDR_WIDTH-1:0] IF_raddr,
  output logic                  rst_p_valid,
  output logic                  update_end_ptr,
  output logic [ADDR_WIDTH-1:0] end_ptr_out,
  output logic                  if_free,
  output logic [LEN_W-1:0]      free_num,
  output logic                  busy,
  output logic                  done,
  output logic                  param_err
);

  localparam logic [31:0] DEPTH_L = 32'(DEPTH);

  state_t state, state_d;

  logic [ADDR_WIDTH-1:0] head, offset, end_ptr;
  logic [CNT_W-1:0]      win;
  logic [LEN_W-1:0]      fl_q, st_q;
  logic [CNT_W-1:0]      nw_q;

  logic [ADDR_WIDTH-1:0] raddr_sum, end_sum, head_next;
  logic [LEN_W-1:0]      need;
  logic                  params_bad, start_legal, data_ok, last_read, last_win;

  circ_addr_add #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_add_raddr (
    .a(head), .b(offset), .sum(raddr_sum)
  );

  circ_addr_add #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_add_end (
    .a(head), .b(ADDR_WIDTH'(fl_q - LEN_W'(1))), .sum(end_sum)
  );

  // stride == DEPTH == 2**ADDR_WIDTH truncates to 0, which is the correct residue
  circ_addr_add #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_add_head (
    .a(head), .b(ADDR_WIDTH'(st_q)), .sum(head_next)
  );

  always_comb begin
    params_bad  = (filt_len == '0) || (stride == '0) ||
                  (32'(filt_len) > DEPTH_L) || (32'(stride) > DEPTH_L);
    start_legal = (state == ST_IDLE) && start && !params_bad && (num_windows != '0);
    need        = (fl_q > st_q) ? fl_q : st_q;
    data_ok     = (32'(if_count) >= 32'(need));
    last_read   = ((32'(offset) + 32'd1) == 32'(fl_q));
    last_win    = (({1'b0, win} + 1'b1) == {1'b0, nw_q});
  end

  always_comb begin
    state_d        = state;
    IF_ren         = 1'b0;
    rst_p_valid    = 1'b0;
    update_end_ptr = 1'b0;
    if_free        = 1'b0;
    done           = 1'b0;
    param_err      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (params_bad) begin
            param_err = 1'b1;
          end else if (num_windows == '0) begin
            state_d = ST_DONE;
          end else begin
            rst_p_valid = 1'b1;
            state_d     = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (data_ok) state_d = ST_READ;
      end
      ST_READ: begin
        IF_ren = rd_ready;
        if (rd_ready && last_read) state_d = ST_PUBLISH;
      end
      ST_PUBLISH: begin
        update_end_ptr = 1'b1;
        state_d        = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        if_free = 1'b1;
        if (last_win) begin
          state_d = ST_DONE;
        end else begin
          rst_p_valid = 1'b1;
          state_d     = ST_WAIT;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      head    <= '0;
      offset  <= '0;
      end_ptr <= '0;
      win     <= '0;
      fl_q    <= '0;
      st_q    <= '0;
      nw_q    <= '0;
    end else begin
      state <= state_d;
      if (start_legal) begin
        fl_q <= filt_len;
        st_q <= stride;
        nw_q <= num_windows;
        win  <= '0;
      end
      if (state == ST_WAIT && data_ok) offset <= '0;
      // end pointer lands with the final read so it is valid throughout PUBLISH
      if (state == ST_READ && rd_ready) begin
        offset <= offset + 1'b1;
        if (last_read) end_ptr <= end_sum;
      end
      if (state == ST_ADVANCE) begin
        head <= head_next;
        win  <= win + 1'b1;
      end
    end
  end

  assign IF_raddr    = raddr_sum;
  assign end_ptr_out = end_ptr;
  assign free_num    = if_free ? st_q : '0;
  assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_if_window_reader.sv
// Directed bench for if_window_reader at DEPTH=16: table of whole runs plus stall/reset sequences.
module tb_if_window_reader;

  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int LW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] filt_len = '0;
  logic [LW-1:0] stride = '0;
  logic [CW-1:0] num_windows = '0;
  logic [AW:0]   if_count = '0;
  logic          rd_ready = 1'b0;
  logic          IF_ren;
  logic [AW-1:0] IF_raddr;
  logic          rst_p_valid;
  logic          update_end_ptr;
  logic [AW-1:0] end_ptr_out;
  logic          if_free;
  logic [LW-1:0] free_num;
  logic          busy;
  logic          done;
  logic          param_err;

  if_window_reader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .LEN_W(LW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .filt_len(filt_len), .stride(stride),
    .num_windows(num_windows), .if_count(if_count), .rd_ready(rd_ready),
    .IF_ren(IF_ren), .IF_raddr(IF_raddr), .rst_p_valid(rst_p_valid),
    .update_end_ptr(update_end_ptr), .end_ptr_out(end_ptr_out), .if_free(if_free),
    .free_num(free_num), .busy(busy), .done(done), .param_err(param_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LW-1:0] fl;
    logic [LW-1:0] st;
    logic [CW-1:0] nw;
    int exp_perr;
    int exp_reads;
    int exp_first;
    int exp_last;
    int exp_end;
    int exp_free;
  } vec_t;

  int n_assert = 0;
  int n_fail = 0;
  int mhead = 0;

  // passive monitor, sampled on the falling edge
  logic mon_en = 1'b0;
  int rd_q[$];
  int ep_q[$];
  int free_sum, rpv_cnt, coll_cnt, done_cnt, perr_cnt, bad_free;

  always @(negedge clk) begin
    if (mon_en) begin
      if (IF_ren) rd_q.push_back(int'(IF_raddr));
      if (update_end_ptr) ep_q.push_back(int'(end_ptr_out));
      if (if_free) free_sum += int'(free_num);
      else if (free_num != '0) bad_free++;
      if (rst_p_valid) rpv_cnt++;
      if (rst_p_valid && update_end_ptr) coll_cnt++;
      if (done) done_cnt++;
      if (param_err) perr_cnt++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    rd_q.delete();
    ep_q.delete();
    free_sum = 0; rpv_cnt = 0; coll_cnt = 0;
    done_cnt = 0; perr_cnt = 0; bad_free = 0;
  endtask

  task automatic pulse_start(input logic [LW-1:0] fl, input logic [LW-1:0] st,
                             input logic [CW-1:0] nw);
    @(posedge clk); #1;
    mon_en = 1'b1;
    filt_len = fl; stride = st; num_windows = nw; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int n;
    n = 0;
    while (done_cnt == 0 && perr_cnt == 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " timeout"}, (n >= 400) ? 1 : 0, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string p);
    @(negedge clk);
    check({p, " IF_ren"}, int'(IF_ren), 0);
    check({p, " IF_raddr"}, int'(IF_raddr), 0);
    check({p, " rst_p_valid"}, int'(rst_p_valid), 0);
    check({p, " update_end_ptr"}, int'(update_end_ptr), 0);
    check({p, " end_ptr_out"}, int'(end_ptr_out), 0);
    check({p, " if_free"}, int'(if_free), 0);
    check({p, " free_num"}, int'(free_num), 0);
    check({p, " busy"}, int'(busy), 0);
    check({p, " done"}, int'(done), 0);
    check({p, " param_err"}, int'(param_err), 0);
  endtask

  // compare recorded reads/end pointers against the window walk from head h0
  task automatic check_walk(input string p, input int h0, input int fl, input int st,
                            input int nw_exp);
    for (int k = 0; k < rd_q.size(); k++)
      check($sformatf("%s raddr[%0d]", p, k), rd_q[k], (h0 + (k / fl) * st + (k % fl)) % DEPTH);
    check({p, " publishes"}, ep_q.size(), nw_exp);
    for (int w = 0; w < ep_q.size(); w++)
      check($sformatf("%s end_ptr[%0d]", p, w), ep_q[w], (h0 + w * st + fl - 1) % DEPTH);
    check({p, " collisions"}, coll_cnt, 0);
    check({p, " free_num idle"}, bad_free, 0);
  endtask

  task automatic run_vec(input string p, input vec_t v);
    int legal_nw;
    clear_mon();
    if_count = 5'd16;
    rd_ready = 1'b1;
    pulse_start(v.fl, v.st, v.nw);
    wait_end(p);
    legal_nw = (v.exp_perr != 0) ? 0 : int'(v.nw);
    check({p, " param_err"}, perr_cnt, v.exp_perr);
    check({p, " done"}, done_cnt, (v.exp_perr != 0) ? 0 : 1);
    check({p, " reads"}, rd_q.size(), v.exp_reads);
    if (v.exp_reads > 0 && rd_q.size() > 0) begin
      check({p, " first raddr"}, rd_q[0], v.exp_first);
      check({p, " last raddr"}, rd_q[rd_q.size()-1], v.exp_last);
    end
    if (ep_q.size() > 0) check({p, " final end_ptr"}, ep_q[ep_q.size()-1], v.exp_end);
    check({p, " free sum"}, free_sum, v.exp_free);
    check({p, " rst_p_valid"}, rpv_cnt, legal_nw);
    check_walk(p, mhead, int'(v.fl), int'(v.st), legal_nw);
    @(negedge clk);
    check({p, " busy after"}, int'(busy), 0);
    mhead = (mhead + legal_nw * int'(v.st)) % DEPTH;
    mon_en = 1'b0;
  endtask

  vec_t vecs[11];
  vec_t vx;

  initial begin
    //            fl     st     nw     perr rds first last end free
    vecs[0]  = '{8'd3,  8'd1,  16'd2, 0,   6,  0,    3,   3,  2};
    vecs[1]  = '{8'd1,  8'd12, 16'd1, 0,   1,  2,    2,   2,  12};
    vecs[2]  = '{8'd4,  8'd2,  16'd1, 0,   4,  14,   1,   1,  2};
    vecs[3]  = '{8'd0,  8'd1,  16'd1, 1,   0,  0,    0,   0,  0};
    vecs[4]  = '{8'd17, 8'd1,  16'd1, 1,   0,  0,    0,   0,  0};
    vecs[5]  = '{8'd3,  8'd0,  16'd1, 1,   0,  0,    0,   0,  0};
    vecs[6]  = '{8'd2,  8'd17, 16'd1, 1,   0,  0,    0,   0,  0};
    vecs[7]  = '{8'd3,  8'd1,  16'd0, 0,   0,  0,    0,   0,  0};
    vecs[8]  = '{8'd16, 8'd16, 16'd1, 0,   16, 0,    15,  15, 16};
    vecs[9]  = '{8'd5,  8'd3,  16'd3, 0,   15, 0,    10,  10, 9};
    vecs[10] = '{8'd2,  8'd7,  16'd2, 0,   4,  9,    1,   1,  14};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_idle_zero("reset");

    for (int i = 0; i < 11; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // slow data arrival then rd_ready throttling, from a clean head
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    mhead = 0;
    clear_mon();
    if_count = 5'd3;
    rd_ready = 1'b0;
    pulse_start(8'd4, 8'd1, 16'd1);
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    check("starve reads", rd_q.size(), 0);
    check("starve busy", int'(busy), 1);
    @(posedge clk); #1 if_count = 5'd4;
    @(posedge clk); #1;
    @(negedge clk);
    check("stall0 IF_ren", int'(IF_ren), 0);
    check("stall0 raddr", int'(IF_raddr), 0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1 rd_ready = (i % 2 == 0);
      if (i == 1) begin
        @(negedge clk);
        check("stall1 raddr", int'(IF_raddr), 1);
        check("stall1 IF_ren", int'(IF_ren), 0);
      end
    end
    rd_ready = 1'b1;
    wait_end("throttle");
    check("throttle reads", rd_q.size(), 4);
    check("throttle done", done_cnt, 1);
    check_walk("throttle", mhead, 4, 1, 1);
    mhead = 1;
    mon_en = 1'b0;

    // stride larger than filt_len sets the occupancy requirement
    clear_mon();
    if_count = 5'd4;
    rd_ready = 1'b1;
    pulse_start(8'd3, 8'd5, 16'd1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("need5 reads", rd_q.size(), 0);
    check("need5 busy", int'(busy), 1);
    @(posedge clk); #1 if_count = 5'd5;
    wait_end("need5");
    check("need5 reads after", rd_q.size(), 3);
    check("need5 free sum", free_sum, 5);
    check_walk("need5", mhead, 3, 5, 1);
    mhead = 6;
    mon_en = 1'b0;

    // reset during the second read cycle abandons the window
    clear_mon();
    if_count = 5'd16;
    rd_ready = 1'b1;
    pulse_start(8'd4, 8'd1, 16'd1);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    mon_en = 1'b0;
    check_idle_zero("midrst");
    check("midrst publishes", ep_q.size(), 0);
    check("midrst free", free_sum, 0);
    check("midrst done", done_cnt, 0);
    mhead = 0;
    vx = '{8'd3, 8'd2, 16'd1, 0, 3, 0, 2, 2, 2};
    run_vec("restart", vx);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
